// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM-side control blocks.
//   CMD_WRITE / CMD_READ : header command codes carried in header bits [7:0]
//   MEM_BE_ALL           : full-word byte enable
//   seq_state_e          : SPI-to-RAM sequencer states
//   cmd_is_valid()       : true for a recognised header command
package ram_ctrl_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [3:0] MEM_BE_ALL = 4'hF;

  typedef enum logic [3:0] {
    StIdle,
    StGetAddr,
    StGetSize,
    StWrData,
    StWrReq,
    StRdReq,
    StRdWait,
    StRdSend,
    StFinish
  } seq_state_e;

  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/spi_ram_sequencer.sv
// Turns a stream of 32-bit SPI words into RAM transactions.
// A command is three words: header (cmd in [7:0]), start byte address, word count.
// WRITE then streams count data words into RAM; READ fetches count words and returns
// them on the tx stream. One RAM transaction is outstanding at a time.
//
// Ports
//   clk_sys, rst_sys             clock, synchronous active-high reset
//   rx_valid/rx_data/rx_ready    incoming SPI words (valid/ready)
//   tx_valid/tx_data/tx_ready    read-back words (valid/ready)
//   mem_req/mem_gnt/mem_we/mem_be/mem_addr/mem_wdata
//                                RAM request channel, request accepted on req & gnt
//   mem_rvalid/mem_rdata         RAM read response, at least one cycle after gnt
//   busy                         high whenever not idle
//   done                         one-cycle pulse on command completion
//   cmd_err                      one-cycle pulse on an unknown header command
//
// All control outputs are flops loaded from the next-state decode, so they change
// together with the state register and never glitch.
module spi_ram_sequencer
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SIZE_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  // SPI receive stream
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  output logic             rx_ready,
  // read-back stream
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ready,
  // RAM port
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  // status
  output logic             busy,
  output logic             done,
  output logic             cmd_err
);

  seq_state_e state_q, state_d;

  logic [WIDTH-1:0]  addr_q,    addr_d;
  logic [SIZE_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0]  wdata_q,   wdata_d;
  logic [WIDTH-1:0]  tx_data_q, tx_data_d;
  logic              is_write_q, is_write_d;

  // Registered outputs and their next values
  logic rx_ready_q, rx_ready_d;
  logic tx_valid_q, tx_valid_d;
  logic mem_req_q,  mem_req_d;
  logic mem_we_q,   mem_we_d;
  logic busy_q,     busy_d;
  logic done_q,     done_d;
  logic cmd_err_q,  cmd_err_d;

  logic rx_fire;
  logic tx_fire;
  logic last_word;

  assign rx_fire   = rx_valid & rx_ready_q;
  assign tx_fire   = tx_valid_q & tx_ready;
  assign last_word = (cnt_q == SIZE_W'(1));

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q    <= StIdle;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
      is_write_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
      is_write_q <= is_write_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    is_write_d = is_write_q;
    cmd_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          if (cmd_is_valid(rx_data[7:0])) begin
            is_write_d = (rx_data[7:0] == CMD_WRITE);
            state_d    = StGetAddr;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end

      StGetAddr: begin
        if (rx_fire) begin
          addr_d  = {rx_data[WIDTH-1:2], 2'b00};
          state_d = StGetSize;
        end
      end

      StGetSize: begin
        if (rx_fire) begin
          cnt_d = rx_data[SIZE_W-1:0];
          if (rx_data[SIZE_W-1:0] == '0) begin
            state_d = StFinish;
          end else if (is_write_q) begin
            state_d = StWrData;
          end else begin
            state_d = StRdReq;
          end
        end
      end

      StWrData: begin
        if (rx_fire) begin
          wdata_d = rx_data;
          state_d = StWrReq;
        end
      end

      StWrReq: begin
        if (mem_gnt) begin
          addr_d  = addr_q + WIDTH'(4);
          cnt_d   = cnt_q - SIZE_W'(1);
          state_d = last_word ? StFinish : StWrData;
        end
      end

      StRdReq: begin
        if (mem_gnt) begin
          addr_d  = addr_q + WIDTH'(4);
          state_d = StRdWait;
        end
      end

      StRdWait: begin
        if (mem_rvalid) begin
          tx_data_d = mem_rdata;
          state_d   = StRdSend;
        end
      end

      StRdSend: begin
        if (tx_fire) begin
          cnt_d   = cnt_q - SIZE_W'(1);
          state_d = last_word ? StFinish : StRdReq;
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the upcoming state, loaded into the output flops
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_ready_d = 1'b0;
    tx_valid_d = 1'b0;
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StFinish);

    unique case (state_d)
      StIdle, StGetAddr, StGetSize, StWrData: begin
        rx_ready_d = 1'b1;
      end
      StWrReq: begin
        mem_req_d = 1'b1;
        mem_we_d  = 1'b1;
      end
      StRdReq: begin
        mem_req_d = 1'b1;
      end
      StRdSend: begin
        tx_valid_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign rx_ready  = rx_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = MEM_BE_ALL;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_sequencer.sv
// Directed bench for spi_ram_sequencer: a RAM responder with programmable grant and
// read latency, a tx consumer with programmable stall, and hand-computed expectations.
module tb_spi_ram_sequencer;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SIZE_W = 16;

  localparam logic [31:0] WORD_A = 32'hA5A5_0001;
  localparam logic [31:0] WORD_B = 32'h5A5A_0002;
  localparam logic [31:0] WORD_C = 32'hC3C3_0003;
  localparam logic [31:0] WORD_D = 32'hDEAD_0004;
  localparam logic [31:0] WORD_E = 32'hBEEF_0005;
  localparam logic [31:0] WORD_F = 32'hF00D_0006;

  logic             clk_sys = 1'b0;
  logic             rst_sys;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_ready;
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  logic             mem_req;
  logic             mem_gnt;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;
  logic             busy;
  logic             done;
  logic             cmd_err;

  spi_ram_sequencer #(
    .WIDTH  (WIDTH),
    .SIZE_W (SIZE_W)
  ) u_dut (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // RAM responder, tx consumer and event counters, all evaluated on the falling edge
  // ---------------------------------------------------------------------------
  int          gnt_delay = 0;
  int          rv_delay  = 1;
  int          tx_stall  = 0;
  int          wait_cnt  = 0;
  int          rv_cnt    = 0;
  int          tx_wait   = 0;
  logic [31:0] rv_data   = '0;
  logic        held      = 1'b0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;
  logic        tx_held   = 1'b0;
  logic [31:0] tx_hold_data;

  int done_cnt   = 0;
  int err_cnt    = 0;
  int req_cycles = 0;
  int stab_err   = 0;

  logic [31:0] ram [logic [31:0]];
  logic [31:0] txn_addr [$];
  logic [31:0] txn_data [$];
  logic        txn_we   [$];
  logic [31:0] tx_words [$];

  always @(negedge clk_sys) begin
    mem_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rv_data;
      end
    end

    mem_gnt = 1'b0;
    if (mem_req) begin
      req_cycles++;
      if (held) begin
        if (mem_addr !== hold_addr || mem_we !== hold_we || mem_wdata !== hold_wdata) stab_err++;
      end else begin
        held       = 1'b1;
        hold_addr  = mem_addr;
        hold_we    = mem_we;
        hold_wdata = mem_wdata;
      end
      if (wait_cnt >= gnt_delay) begin
        mem_gnt  = 1'b1;
        wait_cnt = 0;
        held     = 1'b0;
        txn_addr.push_back(mem_addr);
        txn_we.push_back(mem_we);
        txn_data.push_back(mem_wdata);
        if (mem_we) begin
          ram[mem_addr] = mem_wdata;
        end else begin
          rv_cnt  = rv_delay;
          rv_data = ram.exists(mem_addr) ? ram[mem_addr] : 32'h0BAD_0BAD;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      held     = 1'b0;
    end

    tx_ready = 1'b0;
    if (tx_valid) begin
      if (!tx_held) begin
        tx_held      = 1'b1;
        tx_hold_data = tx_data;
        tx_wait      = tx_stall;
      end else if (tx_data !== tx_hold_data) begin
        stab_err++;
      end
      if (tx_wait > 0) begin
        tx_wait--;
      end else begin
        tx_ready = 1'b1;
        tx_words.push_back(tx_data);
        tx_held = 1'b0;
      end
    end else begin
      tx_held = 1'b0;
    end

    if (done)    done_cnt++;
    if (cmd_err) err_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called on a falling edge, return on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = w;
    while (!rx_ready && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("rx word accepted", 32'(rx_ready), 32'd1);
    @(negedge clk_sys);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq({tag, " returns idle"}, 32'(busy), 32'd0);
    @(negedge clk_sys);
  endtask

  task automatic clear_logs();
    txn_addr.delete();
    txn_data.delete();
    txn_we.delete();
    tx_words.delete();
    stab_err = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  int done0, err0, req0;

  initial begin
    rst_sys    = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = '0;
    tx_ready   = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset values
    repeat (3) @(negedge clk_sys);
    check_eq("reset rx_ready", 32'(rx_ready), 32'd0);
    check_eq("reset mem_req",  32'(mem_req),  32'd0);
    check_eq("reset mem_be",   32'(mem_be),   32'hF);
    check_eq("reset tx_valid", 32'(tx_valid), 32'd0);
    check_eq("reset busy",     32'(busy),     32'd0);
    check_eq("reset done",     32'(done),     32'd0);
    check_eq("reset mem_addr", mem_addr,      32'd0);
    rst_sys = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_eq("idle rx_ready", 32'(rx_ready), 32'd1);

    // 1: WRITE 3 words at 0x100, grant in the request cycle
    clear_logs();
    done0 = done_cnt;
    gnt_delay = 0;
    send_word(32'h0000_0001);
    send_word(32'h0000_0100);
    send_word(32'h0000_0003);
    send_word(WORD_A);
    send_word(WORD_B);
    send_word(WORD_C);
    wait_idle("t1");
    check_eq("t1 txn count", 32'(txn_addr.size()), 32'd3);
    check_eq("t1 addr0", txn_addr[0], 32'h100);
    check_eq("t1 addr1", txn_addr[1], 32'h104);
    check_eq("t1 addr2", txn_addr[2], 32'h108);
    check_eq("t1 data0", txn_data[0], WORD_A);
    check_eq("t1 data1", txn_data[1], WORD_B);
    check_eq("t1 data2", txn_data[2], WORD_C);
    check_eq("t1 we2",   32'(txn_we[2]), 32'd1);
    check_eq("t1 done count", 32'(done_cnt - done0), 32'd1);

    // 2: READ 2 words at 0x100, rvalid two cycles late, consumer stalls 5 cycles
    clear_logs();
    done0 = done_cnt;
    rv_delay = 3;
    tx_stall = 5;
    send_word(32'h0000_0002);
    send_word(32'h0000_0100);
    send_word(32'h0000_0002);
    wait_idle("t2");
    check_eq("t2 tx count", 32'(tx_words.size()), 32'd2);
    check_eq("t2 tx word0", tx_words[0], WORD_A);
    check_eq("t2 tx word1", tx_words[1], WORD_B);
    check_eq("t2 rd addr1", txn_addr[1], 32'h104);
    check_eq("t2 rd we0",   32'(txn_we[0]), 32'd0);
    check_eq("t2 stability", 32'(stab_err), 32'd0);
    check_eq("t2 done count", 32'(done_cnt - done0), 32'd1);
    rv_delay = 1;
    tx_stall = 0;

    // 3: unknown header, then a valid READ of one word
    clear_logs();
    err0 = err_cnt;
    req0 = req_cycles;
    send_word(32'h0000_0007);
    check_eq("t3 cmd_err pulse", 32'(cmd_err), 32'd1);
    check_eq("t3 busy after bad hdr", 32'(busy), 32'd0);
    @(negedge clk_sys);
    check_eq("t3 cmd_err one cycle", 32'(cmd_err), 32'd0);
    check_eq("t3 no mem_req", 32'(req_cycles - req0), 32'd0);
    send_word(32'h0000_0002);
    send_word(32'h0000_0108);
    send_word(32'h0000_0001);
    wait_idle("t3");
    check_eq("t3 tx word", tx_words[0], WORD_C);
    check_eq("t3 err count", 32'(err_cnt - err0), 32'd1);

    // 4: size 0 for both commands; upper size bits are ignored
    req0 = req_cycles;
    send_word(32'h0000_0001);
    send_word(32'h0000_0200);
    send_word(32'h0001_0000);
    check_eq("t4 wr done after size", 32'(done), 32'd1);
    wait_idle("t4 wr");
    send_word(32'h0000_0002);
    send_word(32'h0000_0200);
    send_word(32'h0000_0000);
    check_eq("t4 rd done after size", 32'(done), 32'd1);
    wait_idle("t4 rd");
    check_eq("t4 no mem_req", 32'(req_cycles - req0), 32'd0);

    // 5: WRITE across the address wrap with a 4-cycle grant delay
    clear_logs();
    gnt_delay = 4;
    req0 = req_cycles;
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFE);
    send_word(32'h0000_0002);
    send_word(WORD_D);
    send_word(WORD_E);
    wait_idle("t5");
    check_eq("t5 addr0", txn_addr[0], 32'hFFFF_FFFC);
    check_eq("t5 addr1", txn_addr[1], 32'h0000_0000);
    check_eq("t5 data1", txn_data[1], WORD_E);
    check_eq("t5 req cycles", 32'(req_cycles - req0), 32'd10);
    check_eq("t5 stability", 32'(stab_err), 32'd0);
    gnt_delay = 0;

    // 6: reset while waiting for read data, then a fresh WRITE
    clear_logs();
    rv_delay = 4;
    send_word(32'h0000_0002);
    send_word(32'h0000_0100);
    send_word(32'h0000_0001);
    @(negedge clk_sys);
    check_eq("t6 in rd_wait busy", 32'(busy), 32'd1);
    check_eq("t6 in rd_wait req", 32'(mem_req), 32'd0);
    rst_sys = 1'b1;
    repeat (2) @(negedge clk_sys);
    check_eq("t6 reset busy", 32'(busy), 32'd0);
    check_eq("t6 reset rx_ready", 32'(rx_ready), 32'd0);
    rst_sys = 1'b0;
    repeat (4) @(negedge clk_sys);
    check_eq("t6 late rvalid tx_valid", 32'(tx_valid), 32'd0);
    check_eq("t6 late rvalid busy", 32'(busy), 32'd0);
    check_eq("t6 no tx words", 32'(tx_words.size()), 32'd0);
    rv_delay = 1;
    done0 = done_cnt;
    send_word(32'h0000_0001);
    send_word(32'h0000_0203);
    send_word(32'h0000_0001);
    send_word(WORD_F);
    wait_idle("t6");
    check_eq("t6 wr addr", txn_addr[1], 32'h200);
    check_eq("t6 wr data", txn_data[1], WORD_F);
    check_eq("t6 done count", 32'(done_cnt - done0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
